mux_arb_2_1: RTL

MUX_ARB_2_1 -- requirements
Module: mux_arb_2_1

---
 rtl/mux_arb_2_1.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mux_arb_2_1.sv
// rtl/mux_arb_2_1.sv - two-source round-robin arbiter onto one registered output channel.
// Define ARB_BURST_EN to let a grant run up to MAX_BURST beats; otherwise every grant is one beat.
module mux_arb_2_1 #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GA   = 2'd1,
    GB   = 2'd2
  } state_t;

`ifdef ARB_BURST_EN
  localparam logic [3:0] BURST_LEN = 4'(MAX_BURST);
`else
  // Single-beat grants; MAX_BURST only shapes burst builds.
  localparam logic [3:0] BURST_LEN = (MAX_BURST > 0) ? 4'd1 : 4'd1;
`endif

  state_t            state_q, state_d;
  logic              last_q, last_d;        // last-served source, 1 = B
  logic              sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              stall;
  logic              can_take;
  logic              a_xfer;
  logic              b_xfer;
  logic              last_beat;
  logic [DATA_W-1:0] mux_data;

  assign stall     = out_valid_q & ~out_ready;
  assign can_take  = ~out_valid_q | out_ready;
  assign a_ready   = (state_q == GA) & can_take;
  assign b_ready   = (state_q == GB) & can_take;
  assign a_xfer    = a_valid & a_ready;
  assign b_xfer    = b_valid & b_ready;
  assign last_beat = (cnt_q + 4'd1) == BURST_LEN;
  assign mux_data  = sel_q ? b_data : a_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          state_d = last_q ? GA : GB;
        end else if (a_valid) begin
          state_d = GA;
        end else if (b_valid) begin
          state_d = GB;
        end
      end
      GA: begin
        if (a_xfer) begin
          if (last_beat) state_d = b_valid ? GB : IDLE;
        end else if (!stall && !a_valid) begin
          state_d = b_valid ? GB : IDLE;
        end
      end
      GB: begin
        if (b_xfer) begin
          if (last_beat) state_d = a_valid ? GA : IDLE;
        end else if (!stall && !b_valid) begin
          state_d = a_valid ? GA : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (a_xfer) begin
      last_d = 1'b0;
    end else if (b_xfer) begin
      last_d = 1'b1;
    end

    // Any grant change starts a fresh beat count.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end else if (a_xfer || b_xfer) begin
      cnt_d = cnt_q + 4'd1;
    end

    case (state_d)
      GA:      sel_d = 1'b0;
      GB:      sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (a_xfer || b_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule
